rom_rd_arbiter: RTL and testbench
=================================

Name: rom_rd_arbiter

Overview:
- Round-robin read arbiter that shares one synchronous 8x8 ROM port between N_REQ requesters.
- Accepts a per-requester request/address, issues exactly one ROM read at a time, waits the ROM read latency, then returns data with a one-cycle valid pulse to the owning requester.
- Checks the ROM's echoed address against the issued address and flags mismatches.
- Sits between client blocks (sequencers, table lookups) and the ROM instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 8, ROM address width.
- DATA_WIDTH, 8, ROM data width.
- ROM_LATENCY, 1, clock edges from the ROM sampling RE/ADDR to ROM data/address-echo being valid (1..4).

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_I  in  1  asynchronous, active-high reset.
- REQ_I  in  N_REQ  per-requester read request; level, held until ACK_O.
- ADDR_I  in  N_REQ*ADDR_WIDTH  packed request addresses; slice i belongs to requester i.
- ACK_O  out  N_REQ  one-hot, one-cycle pulse: request i accepted.
- VALID_O  out  N_REQ  one-hot, one-cycle pulse: DATA_O holds requester i's data.
- DATA_O  out  DATA_WIDTH  returned read data; held until the next response.
- ERR_O  out  1  sticky address-echo mismatch flag.
- ROM_RE_O  out  1  ROM read enable.
- ROM_ADDR_O  out  ADDR_WIDTH  ROM address.
- ROM_DATA_I  in  DATA_WIDTH  ROM data output.
- ROM_ADDR_I  in  ADDR_WIDTH  ROM echoed address output.

Behaviour:
- Reset (async, RST_I=1):
  - state=IDLE; rr_ptr=0.
  - ACK_O, VALID_O, ROM_RE_O, ERR_O = 0; DATA_O and ROM_ADDR_O = 0.
  - Reset mid-transaction aborts it: no VALID_O is produced and the owner must re-request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - At an edge with REQ_I != 0, pick winner w = first set bit searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - Register owner=w and addr_q=ADDR_I[w]; go to ISSUE.
  - Outputs registered: during ISSUE, ACK_O[w]=1, ROM_RE_O=1, ROM_ADDR_O=addr_q.
- ISSUE: lasts exactly one cycle; next state WAIT; load lat_cnt=ROM_LATENCY-1.
- WAIT:
  - ROM_RE_O=0; ROM_ADDR_O holds addr_q.
  - Decrement lat_cnt each edge; when lat_cnt==0 at an edge, go to RESP.
  - For ROM_LATENCY=1, WAIT lasts exactly one cycle.
- RESP transition edge:
  - DATA_O<=ROM_DATA_I and VALID_O[owner]<=1 for one cycle.
  - If ROM_ADDR_I != addr_q, ERR_O<=1 (sticky until reset).
  - rr_ptr<=(owner+1) mod N_REQ.
- RESP: next edge returns to IDLE; new arbitration may happen at that same edge (RESP treated as IDLE for arbitration).
- Latency: REQ seen at edge E0 -> ACK/RE high in cycle after E0 -> VALID_O high in cycle after edge E0+1+ROM_LATENCY.
- Throughput: one read per ROM_LATENCY+2 cycles when back-to-back.
- Requests arriving while busy are ignored until arbitration; REQ_I[i] may drop after ACK_O[i].
- A request deasserted before ACK is silently dropped; no partial state.
- Only one of ACK_O, VALID_O bits set at any time; ACK and VALID never target the same cycle.
- ADDR_I changes after ACK do not affect the in-flight read.

Decomposition:
- Package rom_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP) and function rr_pick(req, ptr) returning the winner index.
- Optional sub-module rr_priority_pick (combinational round-robin picker); FSM, counters and registers stay in rom_rd_arbiter.

Test Plan (N_REQ=4, ROM_LATENCY=1, ROM preloaded with DATA=addr^8'hA5):
- Single request: REQ_I=4'b0010, ADDR slice1=8'h3C at E0 -> ACK_O=4'b0010 cycle after E0, ROM_RE_O=1, ROM_ADDR_O=8'h3C; VALID_O=4'b0010 with DATA_O=8'h99 cycle after E0+2.
- All four request continuously from reset -> grant order 0,1,2,3,0, one grant every 3 cycles; each VALID_O carries its own address's data.
- Req1 and req3 held after a grant to 1 -> next grant to 3, then 1 (wrap-around with rr_ptr=2).
- Force ROM_ADDR_I to differ from 8'h10 during the read of 8'h10 -> ERR_O=1 after RESP and remains 1 through later clean reads until RST_I.
- Assert RST_I in WAIT -> all outputs 0 immediately (async); no VALID_O; after release, a new REQ gets a fresh grant starting from requester 0.
- ROM_LATENCY=3 build: VALID_O appears 5 cycles after the REQ edge; DATA_O is stable between responses.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and the round-robin pick function for the ROM read arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} arb_state_e;

  localparam int unsigned MaxReq = 8;

  // First set bit of req searching upward from ptr, wrapping at n.
  function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int k = MaxReq - 1; k >= 0; k--) begin
      if (k < int'(n)) begin
        idx = {1'b0, ptr} + 4'(k);
        if (idx >= 4'(n)) idx = idx - 4'(n);
        if (req[idx[2:0]]) rr_pick = idx[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker over N_REQ request lines.
module rr_priority_pick
  import rom_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic [2:0]       winner,
  output logic             any
);

  logic [MaxReq-1:0] req_ext;

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
  end

  assign winner = rr_pick(req_ext, ptr, N_REQ);
  assign any    = |req;

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM read port between N_REQ clients.
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic [N_REQ-1:0]            REQ_I,
  input  logic [N_REQ*ADDR_WIDTH-1:0] ADDR_I,
  output logic [N_REQ-1:0]            ACK_O,
  output logic [N_REQ-1:0]            VALID_O,
  output logic [DATA_WIDTH-1:0]       DATA_O,
  output logic                        ERR_O,
  output logic                        ROM_RE_O,
  output logic [ADDR_WIDTH-1:0]       ROM_ADDR_O,
  input  logic [DATA_WIDTH-1:0]       ROM_DATA_I,
  input  logic [ADDR_WIDTH-1:0]       ROM_ADDR_I
);

  arb_state_e            state_q, state_d;
  logic [2:0]            owner_q, owner_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [1:0]            lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic [N_REQ-1:0]      valid_q, valid_d;
  logic                  re_q, re_d;
  logic                  err_q, err_d;

  logic [2:0] winner;
  logic       any_req;

  rr_priority_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req   (REQ_I),
    .ptr   (rr_ptr_q),
    .winner(winner),
    .any   (any_req)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ack_d    = '0;
    valid_d  = '0;
    re_d     = 1'b0;
    err_d    = err_q;
    case (state_q)
      // RESP doubles as an arbitration slot so back-to-back reads lose no cycle.
      StIdle, StResp: begin
        state_d = StIdle;
        if (any_req) begin
          state_d = StIssue;
          owner_d = winner;
          addr_d  = ADDR_I[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          ack_d   = N_REQ'(1) << winner;
          re_d    = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWait;
        lat_d   = 2'(ROM_LATENCY - 1);
      end
      StWait: begin
        if (lat_q == 2'd0) begin
          state_d  = StResp;
          data_d   = ROM_DATA_I;
          valid_d  = N_REQ'(1) << owner_q;
          rr_ptr_d = (owner_q == 3'(N_REQ - 1)) ? 3'd0 : owner_q + 3'd1;
          if (ROM_ADDR_I != addr_q) err_d = 1'b1;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      lat_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ack_q    <= '0;
      valid_q  <= '0;
      re_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      re_q     <= re_d;
      err_q    <= err_d;
    end
  end

  assign ACK_O      = ack_q;
  assign VALID_O    = valid_q;
  assign DATA_O     = data_q;
  assign ERR_O      = err_q;
  assign ROM_RE_O   = re_q;
  assign ROM_ADDR_O = addr_q;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Bench for rom_rd_arbiter: latency-1 and latency-3 instances against a ROM holding addr^8'hA5.
module tb_rom_rd_arbiter;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } resp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] addr;
    logic [7:0]  order;  // expected grant order, 2 bits per grant, first grant in [1:0]
  } vec_t;

  logic        CLK_I, RST_I;
  logic [3:0]  REQ_I, ACK_O, VALID_O;
  logic [31:0] ADDR_I;
  logic [7:0]  DATA_O, ROM_ADDR_O, ROM_DATA_I, ROM_ADDR_I;
  logic        ERR_O, ROM_RE_O;

  logic [3:0]  req3, ack3, valid3;
  logic [31:0] addr3;
  logic [7:0]  data3, rom_addr3, rom_data3, rom_echo3;
  logic        err3, re3;

  logic        bad = 1'b0;
  logic [7:0]  rom1_q = '0;
  logic [7:0]  s0 = '0, s1 = '0, s2 = '0;

  int    errors = 0, checks = 0, cyc = 0, n_acks = 0, last_ack_cyc = -1;
  bit    auto_drop = 1'b1, cont_mode = 1'b0;
  int    ack_q[$];
  resp_t exp_q[$];
  vec_t  vecs[5];

  rom_rd_arbiter #(
    .N_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(1)
  ) u_dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .REQ_I(REQ_I), .ADDR_I(ADDR_I), .ACK_O(ACK_O),
    .VALID_O(VALID_O), .DATA_O(DATA_O), .ERR_O(ERR_O), .ROM_RE_O(ROM_RE_O),
    .ROM_ADDR_O(ROM_ADDR_O), .ROM_DATA_I(ROM_DATA_I), .ROM_ADDR_I(ROM_ADDR_I)
  );

  rom_rd_arbiter #(
    .N_REQ(4), .ADDR_WIDTH(8), .DATA_WIDTH(8), .ROM_LATENCY(3)
  ) u_dut3 (
    .CLK_I(CLK_I), .RST_I(RST_I), .REQ_I(req3), .ADDR_I(addr3), .ACK_O(ack3),
    .VALID_O(valid3), .DATA_O(data3), .ERR_O(err3), .ROM_RE_O(re3),
    .ROM_ADDR_O(rom_addr3), .ROM_DATA_I(rom_data3), .ROM_ADDR_I(rom_echo3)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  // ROM models: one-edge and three-edge read latency.
  always @(posedge CLK_I) if (ROM_RE_O) rom1_q <= ROM_ADDR_O;
  assign ROM_DATA_I = rom1_q ^ 8'hA5;
  assign ROM_ADDR_I = rom1_q ^ (bad ? 8'hFF : 8'h00);

  always @(posedge CLK_I) begin
    if (re3) s0 <= rom_addr3;
    s1 <= s0;
    s2 <= s1;
  end
  assign rom_data3 = s2 ^ 8'hA5;
  assign rom_echo3 = s2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] addr);
    resp_t r;
    r.idx  = 2'(idx);
    r.data = addr ^ 8'hA5;
    ack_q.push_back(idx);
    exp_q.push_back(r);
  endtask

  // Advance one cycle, sample 1 time unit after the edge, score ACK/VALID.
  task automatic tick();
    resp_t e;
    int    ei;
    @(posedge CLK_I);
    #1;
    cyc++;
    chk("ack_valid_excl", 32'(ACK_O != 0 && VALID_O != 0), 0);
    if (ACK_O != 0) begin
      if (ack_q.size() == 0) chk("ack_unexpected", ACK_O, 0);
      else begin
        ei = ack_q.pop_front();
        chk("ack_onehot", ACK_O, 4'b1 << ei);
      end
      if (cont_mode && last_ack_cyc >= 0) chk("ack_spacing", cyc - last_ack_cyc, 3);
      last_ack_cyc = cyc;
      n_acks++;
      if (auto_drop) REQ_I = REQ_I & ~ACK_O;
    end
    if (VALID_O != 0) begin
      if (exp_q.size() == 0) chk("valid_unexpected", VALID_O, 0);
      else begin
        e = exp_q.pop_front();
        chk("valid_onehot", VALID_O, 4'b1 << e.idx);
        chk("valid_data", DATA_O, e.data);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (REQ_I == 0 && ack_q.size() == 0 && exp_q.size() == 0) break;
      tick();
    end
    chk("drain", 32'(REQ_I == 0 && ack_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, idx, ack_t, valid_t, base;
    logic [3:0] v3;
    bit stable_bad;

    vecs[0] = '{4'b1010, 32'h3300_1100, 8'b0000_0111};  // ptr=2: 3 then 1
    vecs[1] = '{4'b1111, 32'hF0E1_D2C3, 8'b0100_1110};  // ptr=2: 2,3,0,1
    vecs[2] = '{4'b0001, 32'h0000_0000, 8'b0000_0000};  // 0
    vecs[3] = '{4'b0101, 32'h0080_00FF, 8'b0000_0010};  // ptr=1: 2,0
    vecs[4] = '{4'b1001, 32'h5A00_0001, 8'b0000_0011};  // ptr=1: 3,0

    RST_I = 1'b1; REQ_I = '0; ADDR_I = '0; req3 = '0; addr3 = '0;
    #1;
    chk("reset_state", {ACK_O, VALID_O, ROM_RE_O, ERR_O, DATA_O, ROM_ADDR_O}, 0);
    tick(); tick();
    RST_I = 1'b0;

    // Single request: exact latency.
    REQ_I = 4'b0010; ADDR_I = 32'h0000_3C00;
    push(1, 8'h3C);
    tick();
    chk("single_ack", ACK_O, 4'b0010);
    chk("single_re", ROM_RE_O, 1);
    chk("single_rom_addr", ROM_ADDR_O, 8'h3C);
    tick();
    chk("single_wait_quiet", {ACK_O, VALID_O, ROM_RE_O}, 0);
    tick();
    chk("single_valid", VALID_O, 4'b0010);
    chk("single_data", DATA_O, 8'h99);
    tick();
    chk("single_valid_pulse", VALID_O, 0);
    chk("single_data_held", DATA_O, 8'h99);

    for (int v = 0; v < 5; v++) begin
      REQ_I = vecs[v].req; ADDR_I = vecs[v].addr;
      n = $countones(vecs[v].req);
      for (int k = 0; k < n; k++) begin
        idx = int'(vecs[v].order[2*k +: 2]);
        push(idx, vecs[v].addr[8*idx +: 8]);
      end
      wait_idle(40);
    end

    // Echo mismatch on the read of 8'h10, then a clean read keeps ERR_O sticky.
    chk("err_clear", ERR_O, 0);
    bad = 1'b1; REQ_I = 4'b0100; ADDR_I = 32'h0010_0000;
    push(2, 8'h10);
    wait_idle(20);
    bad = 1'b0;
    chk("err_set", ERR_O, 1);
    REQ_I = 4'b0001; ADDR_I = 32'h0000_0033;
    push(0, 8'h33);
    wait_idle(20);
    chk("err_sticky", ERR_O, 1);

    // Reset during WAIT aborts the read; pointer restarts at 0.
    REQ_I = 4'b0100; ADDR_I = 32'h0077_0000;
    push(2, 8'h77);
    tick(); tick();
    #2 RST_I = 1'b1;
    #1;
    chk("rst_async_outputs", {ACK_O, VALID_O, ROM_RE_O, ERR_O, DATA_O, ROM_ADDR_O}, 0);
    ack_q.delete(); exp_q.delete(); REQ_I = '0;
    tick(); tick();
    chk("rst_no_valid", VALID_O, 0);
    RST_I = 1'b0;
    REQ_I = 4'b1001; ADDR_I = 32'h4200_0021;
    push(0, 8'h21); push(3, 8'h42);
    wait_idle(20);

    // All four requesting continuously from reset.
    RST_I = 1'b1;
    tick();
    auto_drop = 1'b0; cont_mode = 1'b1; last_ack_cyc = -1;
    REQ_I = 4'b1111; ADDR_I = 32'h4433_2211;
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'h11);
    RST_I = 1'b0;
    base = n_acks;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (n_acks - base >= 5) break;
    end
    REQ_I = '0;
    chk("cont_grants", n_acks - base, 5);
    wait_idle(20);
    auto_drop = 1'b1; cont_mode = 1'b0;

    // Latency-3 instance.
    req3 = 4'b0100; addr3 = 32'h005A_0000;
    ack_t = 0; valid_t = 0; v3 = '0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (ack3 != 0) begin
        ack_t = t;
        req3 = req3 & ~ack3;
      end
      if (valid3 != 0) begin
        valid_t = t;
        v3 = valid3;
        break;
      end
    end
    chk("lat3_ack_cycle", ack_t, 1);
    chk("lat3_valid_cycle", valid_t, 5);
    chk("lat3_valid_vec", v3, 4'b0100);
    chk("lat3_data", data3, 8'hFF);
    req3 = 4'b0001; addr3 = 32'h0000_0001;
    stable_bad = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (ack3 != 0) req3 = req3 & ~ack3;
      if (valid3 != 0) break;
      if (data3 !== 8'hFF) stable_bad = 1'b1;
    end
    chk("lat3_data_stable", stable_bad, 0);
    chk("lat3_valid2", valid3, 4'b0001);
    chk("lat3_data2", data3, 8'hA4);
    chk("lat3_err", err3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
